// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared blink widths and meter state encoding
package blink_pkg;

   localparam int BLINK_WIDTH = 9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEASURE  = 2'd1,
      OVERFLOW = 2'd2
   } meter_state_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered-history toggle detector for a synchronous level
module edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig_in,
   output logic edge_seen
);

   logic prev_in;

   // Remember last cycle's level so any change, rising or falling, is visible
   always_ff @(posedge clock) begin
      if (reset) prev_in <= 1'b0;
      else       prev_in <= sig_in;
   end

   assign edge_seen = sig_in ^ prev_in;

endmodule

// File: rtl/blink_rate_meter.sv
// rtl/blink_rate_meter.sv - measures blink half-period in beat ticks with lock and overflow flags
module blink_rate_meter
   import blink_pkg::*;
#(
   parameter int WIDTH = BLINK_WIDTH,
   parameter int TOL   = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_en,
   input  logic             blink_in,
   output logic [WIDTH-1:0] period,
   output logic             valid,
   output logic             locked,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MAX   = '1;
   localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);

   meter_state_t     state, state_nxt;
   logic [WIDTH-1:0] tick_cnt, tick_nxt;
   logic [WIDTH-1:0] period_nxt;
   logic             valid_nxt, locked_nxt, overflow_nxt;
   logic             have_prev, have_prev_nxt;
   logic             edge_seen;
   logic [WIDTH-1:0] meas, diff;

   edge_detect u_edge (
      .clock     (clock),
      .reset     (reset),
      .sig_in    (blink_in),
      .edge_seen (edge_seen)
   );

   // State and output registers; reset discards any partial interval
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         period    <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         overflow  <= 1'b0;
         have_prev <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_nxt;
         period    <= period_nxt;
         valid     <= valid_nxt;
         locked    <= locked_nxt;
         overflow  <= overflow_nxt;
         have_prev <= have_prev_nxt;
      end
   end

   // Next-state logic; a tick coinciding with an edge belongs to the closing interval
   always_comb begin
      state_nxt     = state;
      tick_nxt      = tick_cnt;
      period_nxt    = period;
      valid_nxt     = 1'b0;
      locked_nxt    = locked;
      overflow_nxt  = overflow;
      have_prev_nxt = have_prev;

      meas = (tick_cnt == MAX) ? MAX : tick_cnt + {{(WIDTH-1){1'b0}}, count_en};
      diff = (meas >= period) ? (meas - period) : (period - meas);

      case (state)
         IDLE: begin
            if (edge_seen) begin
               state_nxt = MEASURE;
               tick_nxt  = '0;
            end
         end
         MEASURE: begin
            if (edge_seen) begin
               period_nxt    = meas;
               valid_nxt     = 1'b1;
               tick_nxt      = '0;
               overflow_nxt  = 1'b0;
               locked_nxt    = have_prev && (diff <= TOL_W);
               have_prev_nxt = 1'b1;
            end else if (count_en) begin
               if (tick_cnt != MAX) begin
                  tick_nxt = tick_cnt + 1'b1;
               end else begin
                  state_nxt     = OVERFLOW;
                  overflow_nxt  = 1'b1;
                  locked_nxt    = 1'b0;
                  have_prev_nxt = 1'b0;
               end
            end
         end
         OVERFLOW: begin
            if (edge_seen) begin
               state_nxt = MEASURE;
               tick_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_blink_rate_meter.sv
// tb/tb_blink_rate_meter.sv - directed self-checking bench for blink_rate_meter
module tb_blink_rate_meter;
   import blink_pkg::*;

   logic       clock = 1'b0;
   logic       reset, count_en, blink_in;
   logic [8:0] period0, period2;
   logic       valid0, locked0, overflow0;
   logic       valid2, locked2, overflow2;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clock = ~clock;

   blink_rate_meter #(.WIDTH(9), .TOL(0)) dut0 (
      .clock(clock), .reset(reset), .count_en(count_en), .blink_in(blink_in),
      .period(period0), .valid(valid0), .locked(locked0), .overflow(overflow0)
   );

   blink_rate_meter #(.WIDTH(9), .TOL(2)) dut2 (
      .clock(clock), .reset(reset), .count_en(count_en), .blink_in(blink_in),
      .period(period2), .valid(valid2), .locked(locked2), .overflow(overflow2)
   );

   task automatic cyc(input logic en, input logic tog);
      count_en = en;
      if (tog) blink_in = ~blink_in;
      @(posedge clock);
      #1;
   endtask

   // mode 0: ticks away from edge; 1: last tick on edge cycle; 2: same but tick omitted
   task automatic interval(input int n, input int mode);
      int k;
      k = (mode == 0) ? n : n - 1;
      for (int i = 0; i < k; i++) begin
         repeat (3) cyc(1'b0, 1'b0);
         cyc(1'b1, 1'b0);
      end
      repeat (3) cyc(1'b0, 1'b0);
      cyc(mode == 1, 1'b1);
   endtask

   task automatic apply_reset();
      reset = 1'b1; count_en = 1'b0; blink_in = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (period0 !== 9'd0) begin n_bad++; $display("FAIL rst_period: got %0d want 0", period0); end
      n_cmp++; if ({valid0, locked0, overflow0} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {valid0, locked0, overflow0}); end
      n_cmp++; if (dut0.state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dut0.state, IDLE); end
   endtask

   task automatic test_steady();
      apply_reset();
      cyc(1'b0, 1'b1);
      n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL t1_arm_valid: got %b want 0", valid0); end
      interval(5, 0);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd5) begin n_bad++; $display("FAIL t1_e2: got valid=%b period=%0d want 1/5", valid0, period0); end
      n_cmp++; if (locked0 !== 1'b0) begin n_bad++; $display("FAIL t1_e2_lock: got %b want 0", locked0); end
      interval(5, 0);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd5 || locked0 !== 1'b1) begin n_bad++; $display("FAIL t1_e3: got v=%b p=%0d l=%b want 1/5/1", valid0, period0, locked0); end
      interval(5, 0);
      n_cmp++; if (locked0 !== 1'b1) begin n_bad++; $display("FAIL t1_e4_lock: got %b want 1", locked0); end
      cyc(1'b0, 1'b0);
      n_cmp++; if (valid0 !== 1'b0 || period0 !== 9'd5) begin n_bad++; $display("FAIL t1_hold: got v=%b p=%0d want 0/5", valid0, period0); end
   endtask

   task automatic test_coincident();
      apply_reset();
      cyc(1'b0, 1'b1);
      interval(5, 1);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd5) begin n_bad++; $display("FAIL t2_coinc: got v=%b p=%0d want 1/5", valid0, period0); end
      interval(5, 1);
      n_cmp++; if (period0 !== 9'd5 || locked0 !== 1'b1) begin n_bad++; $display("FAIL t2_coinc2: got p=%0d l=%b want 5/1", period0, locked0); end
      interval(5, 2);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd4 || locked0 !== 1'b0) begin n_bad++; $display("FAIL t2_omit: got v=%b p=%0d l=%b want 1/4/0", valid0, period0, locked0); end
   endtask

   task automatic test_tolerance();
      apply_reset();
      cyc(1'b0, 1'b1);
      interval(5, 0);
      n_cmp++; if (locked0 !== 1'b0 || locked2 !== 1'b0) begin n_bad++; $display("FAIL t3_first: got l0=%b l2=%b want 0/0", locked0, locked2); end
      interval(5, 0);
      n_cmp++; if (locked0 !== 1'b1 || locked2 !== 1'b1) begin n_bad++; $display("FAIL t3_second: got l0=%b l2=%b want 1/1", locked0, locked2); end
      interval(7, 0);
      n_cmp++; if (period0 !== 9'd7 || locked0 !== 1'b0) begin n_bad++; $display("FAIL t3_tol0: got p=%0d l=%b want 7/0", period0, locked0); end
      n_cmp++; if (valid2 !== 1'b1 || period2 !== 9'd7 || locked2 !== 1'b1) begin n_bad++; $display("FAIL t3_tol2: got v=%b p=%0d l=%b want 1/7/1", valid2, period2, locked2); end
   endtask

   task automatic test_overflow();
      apply_reset();
      cyc(1'b0, 1'b1);
      interval(5, 0);
      interval(5, 0);
      n_cmp++; if (locked0 !== 1'b1) begin n_bad++; $display("FAIL t4_prelock: got %b want 1", locked0); end
      for (int i = 1; i <= 600; i++) begin
         cyc(1'b0, 1'b0);
         cyc(1'b1, 1'b0);
         if (i == 511) begin
            n_cmp++; if (overflow0 !== 1'b0) begin n_bad++; $display("FAIL t4_tick511: got %b want 0", overflow0); end
         end
         if (i == 512) begin
            n_cmp++; if (overflow0 !== 1'b1 || locked0 !== 1'b0 || valid0 !== 1'b0) begin n_bad++; $display("FAIL t4_tick512: got o=%b l=%b v=%b want 1/0/0", overflow0, locked0, valid0); end
         end
      end
      n_cmp++; if (dut0.state !== OVERFLOW || overflow2 !== 1'b1) begin n_bad++; $display("FAIL t4_state: got %0d o2=%b want %0d/1", dut0.state, overflow2, OVERFLOW); end
      cyc(1'b0, 1'b1);
      n_cmp++; if (valid0 !== 1'b0 || overflow0 !== 1'b1) begin n_bad++; $display("FAIL t4_reedge: got v=%b o=%b want 0/1", valid0, overflow0); end
      interval(5, 0);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd5 || overflow0 !== 1'b0 || locked0 !== 1'b0) begin n_bad++; $display("FAIL t4_recover: got v=%b p=%0d o=%b l=%b want 1/5/0/0", valid0, period0, overflow0, locked0); end
   endtask

   task automatic test_max_boundary();
      apply_reset();
      cyc(1'b0, 1'b1);
      repeat (511) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd511 || overflow0 !== 1'b0) begin n_bad++; $display("FAIL max_edge_wins: got v=%b p=%0d o=%b want 1/511/0", valid0, period0, overflow0); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      cyc(1'b0, 1'b1);
      interval(5, 0);
      repeat (3) begin cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); end
      reset = 1'b1; blink_in = 1'b0;
      cyc(1'b0, 1'b0);
      n_cmp++; if (period0 !== 9'd0 || {valid0, locked0, overflow0} !== 3'b000) begin n_bad++; $display("FAIL t5_reset: got p=%0d flags=%b want 0/000", period0, {valid0, locked0, overflow0}); end
      n_cmp++; if (dut0.state !== IDLE) begin n_bad++; $display("FAIL t5_state: got %0d want %0d", dut0.state, IDLE); end
      reset = 1'b0;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL t5_arm: got %b want 0", valid0); end
      interval(5, 0);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd5 || locked0 !== 1'b0) begin n_bad++; $display("FAIL t5_after: got v=%b p=%0d l=%b want 1/5/0", valid0, period0, locked0); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cyc(1'b0, 1'b1);
      repeat (3) begin cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); end
      cyc(1'b0, 1'b1);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd3) begin n_bad++; $display("FAIL t6_first: got v=%b p=%0d want 1/3", valid0, period0); end
      cyc(1'b0, 1'b1);
      n_cmp++; if (valid0 !== 1'b1 || period0 !== 9'd0) begin n_bad++; $display("FAIL t6_zero: got v=%b p=%0d want 1/0", valid0, period0); end
      cyc(1'b0, 1'b0);
      n_cmp++; if (valid0 !== 1'b0 || period0 !== 9'd0) begin n_bad++; $display("FAIL t6_hold: got v=%b p=%0d want 0/0", valid0, period0); end
   endtask

   initial begin
      reset = 1'b1; count_en = 1'b0; blink_in = 1'b0;
      test_reset();
      test_steady();
      test_coincident();
      test_tolerance();
      test_overflow();
      test_max_boundary();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
